// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcodes, load/store funct3 codes and the
// memory-stage state and writeback types.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
  localparam logic [6:0] OPCODE_REG_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_REG_REG = 7'b0110011;
  localparam logic [6:0] OPCODE_JAL     = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR    = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    OUT  = 2'd3
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_t;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    logic            reg_write;
  } mem_wb_t;

  // Unsupported funct3 encodings fall back to a full-word access.
  function automatic access_size_t access_size(input logic [2:0] funct3,
                                               input logic       is_store);
    access_size_t sz;
    sz = SZ_WORD;
    if (is_store) begin
      case (funct3)
        F3_SB:   sz = SZ_BYTE;
        F3_SH:   sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: sz = SZ_BYTE;
        F3_LH, F3_LHU: sz = SZ_HALF;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic       is_store,
                                         input logic [1:0] a);
    logic mis;
    mis = 1'b0;
    case (access_size(funct3, is_store))
      SZ_HALF: mis = a[0];
      SZ_WORD: mis = (a != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic writes_rd(input logic [6:0] opcode,
                                     input logic [4:0] rd);
    logic wr;
    case (opcode)
      OPCODE_REG_REG, OPCODE_REG_IMM, OPCODE_JAL, OPCODE_JALR: wr = (rd != 5'd0);
      default:                                                 wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store enables/replicated data and
// load-word extraction with sign or zero extension.
module mem_lane_align
  import riscv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2:0]   funct3,
  input  logic         is_store,
  input  logic [1:0]   a,
  input  logic [N-1:0] rs2,
  input  logic [N-1:0] rdata,
  output logic [3:0]   be,
  output logic [N-1:0] wdata,
  output logic [N-1:0] load_data
);

  access_size_t sz;
  logic [N-1:0] shifted;

  assign sz      = access_size(funct3, is_store);
  assign shifted = rdata >> {a, 3'b000};

  always_comb begin
    be    = 4'b1111;
    wdata = rs2;
    case (sz)
      SZ_BYTE: begin
        be    = 4'b0001 << a;
        wdata = {4{rs2[7:0]}};
      end
      SZ_HALF: begin
        be    = 4'b0011 << a;
        wdata = {2{rs2[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = rs2;
      end
    endcase
  end

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_LB:   load_data = {{(N-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data = {{(N-16){shifted[15]}}, shifted[15:0]};
      F3_LBU:  load_data = {{(N-8){1'b0}}, shifted[7:0]};
      F3_LHU:  load_data = {{(N-16){1'b0}}, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: execute -> data memory -> writeback.
// Optional misaligned-access trap enabled by MEM_STAGE_MISALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | empty, ready for a new instruction
// REQ   | dmem request outstanding, fields held until ack
// RESP  | load acked, waiting for rvalid
// OUT   | result held for writeback until mw_ready
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         em_valid,
  output logic         em_ready,
  input  logic [6:0]   em_opcode,
  input  logic [2:0]   em_funct3,
  input  logic [N-1:0] em_alu_result,
  input  logic [N-1:0] em_rs2_data,
  input  logic [4:0]   em_rd,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [N-1:0] dmem_addr,
  output logic [3:0]   dmem_be,
  output logic [N-1:0] dmem_wdata,
  input  logic         dmem_ack,
  input  logic         dmem_rvalid,
  input  logic [N-1:0] dmem_rdata,
  output logic         mw_valid,
  input  logic         mw_ready,
  output logic [4:0]   mw_rd,
  output logic [N-1:0] mw_result,
  output logic         mw_reg_write,
  output logic         misalign_exc
);

  mem_state_t   state_q, state_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] rs2_q, rs2_d;
  logic [2:0]   funct3_q, funct3_d;
  logic [4:0]   rd_q, rd_d;
  logic         store_q, store_d;
  mem_wb_t      mw_q, mw_d;
  logic         misalign_d;

  logic         accept;
  logic         em_is_mem;
  logic         em_is_store;
  logic         em_misaligned;
  logic [3:0]   lane_be;
  logic [N-1:0] lane_wdata;
  logic [N-1:0] load_data;

  assign em_ready    = (state_q == IDLE) || ((state_q == OUT) && mw_ready);
  assign accept      = em_valid && em_ready;
  assign em_is_store = (em_opcode == OPCODE_STORE);
  assign em_is_mem   = (em_opcode == OPCODE_LOAD) || em_is_store;

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  assign em_misaligned = em_is_mem && is_misaligned(em_funct3, em_is_store, em_alu_result[1:0]);
`else
  assign em_misaligned = 1'b0;
`endif

  mem_lane_align #(.N(N)) u_lane_align (
    .funct3    (funct3_q),
    .is_store  (store_q),
    .a         (addr_q[1:0]),
    .rs2       (rs2_q),
    .rdata     (dmem_rdata),
    .be        (lane_be),
    .wdata     (lane_wdata),
    .load_data (load_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rs2_d      = rs2_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    store_d    = store_q;
    mw_d       = mw_q;
    misalign_d = 1'b0;

    case (state_q)
      REQ: begin
        if (dmem_ack) begin
          if (store_q) begin
            state_d = IDLE;
          end else if (dmem_rvalid) begin
            state_d      = OUT;
            mw_d.rd      = rd_q;
            mw_d.result  = load_data;
            mw_d.reg_write = (rd_q != 5'd0);
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          state_d        = OUT;
          mw_d.rd        = rd_q;
          mw_d.result    = load_data;
          mw_d.reg_write = (rd_q != 5'd0);
        end
      end
      OUT: begin
        if (mw_ready) state_d = IDLE;
      end
      default: state_d = state_q;
    endcase

    // A new accept overrides whatever the current state decided above.
    if (accept) begin
      if (em_is_mem) begin
        if (em_misaligned) begin
          state_d    = IDLE;
          misalign_d = 1'b1;
        end else begin
          state_d  = REQ;
          addr_d   = em_alu_result;
          rs2_d    = em_rs2_data;
          funct3_d = em_funct3;
          rd_d     = em_rd;
          store_d  = em_is_store;
        end
      end else begin
        state_d        = OUT;
        mw_d.rd        = em_rd;
        mw_d.result    = em_alu_result;
        mw_d.reg_write = writes_rd(em_opcode, em_rd);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rs2_q    <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      store_q  <= 1'b0;
      mw_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rs2_q    <= rs2_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      store_q  <= store_d;
      mw_q     <= mw_d;
    end
  end

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  logic misalign_q;
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
  assign misalign_exc = misalign_q;
`else
  assign misalign_exc = 1'b0;
`endif

  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = dmem_req && store_q;
  assign dmem_addr  = dmem_req ? {addr_q[N-1:2], 2'b00} : '0;
  assign dmem_be    = dmem_req ? lane_be : 4'b0000;
  assign dmem_wdata = dmem_we ? lane_wdata : '0;

  assign mw_valid     = (state_q == OUT);
  assign mw_rd        = mw_valid ? mw_q.rd : 5'd0;
  assign mw_result    = mw_valid ? mw_q.result : '0;
  assign mw_reg_write = mw_valid && mw_q.reg_write;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: forwarding, stores, loads with
// waits and backpressure, misaligned access and mid-transaction reset.
module tb_mem_access_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        em_valid;
  logic        em_ready;
  logic [6:0]  em_opcode;
  logic [2:0]  em_funct3;
  logic [31:0] em_alu_result;
  logic [31:0] em_rs2_data;
  logic [4:0]  em_rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mw_valid;
  logic        mw_ready;
  logic [4:0]  mw_rd;
  logic [31:0] mw_result;
  logic        mw_reg_write;
  logic        misalign_exc;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.N(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .em_valid      (em_valid),
    .em_ready      (em_ready),
    .em_opcode     (em_opcode),
    .em_funct3     (em_funct3),
    .em_alu_result (em_alu_result),
    .em_rs2_data   (em_rs2_data),
    .em_rd         (em_rd),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .mw_valid      (mw_valid),
    .mw_ready      (mw_ready),
    .mw_rd         (mw_rd),
    .mw_result     (mw_result),
    .mw_reg_write  (mw_reg_write),
    .misalign_exc  (misalign_exc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic [4:0] rd);
    em_valid      = 1'b1;
    em_opcode     = op;
    em_funct3     = f3;
    em_alu_result = alu;
    em_rs2_data   = rs2;
    em_rd         = rd;
  endtask

  initial begin
    rst = 1'b1;
    em_valid = 1'b0; em_opcode = '0; em_funct3 = '0; em_alu_result = '0;
    em_rs2_data = '0; em_rd = '0;
    dmem_ack = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    mw_ready = 1'b1;
    tick(); tick();

    chk("rst_em_ready", {31'd0, em_ready}, 32'd1);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_mw_valid", {31'd0, mw_valid}, 32'd0);
    chk("rst_mw_result", mw_result, 32'd0);
    chk("rst_misalign", {31'd0, misalign_exc}, 32'd0);
    rst = 1'b0;

    // Back-to-back non-memory ops
    drive(OPCODE_REG_REG, 3'd0, 32'h0000_1234, 32'd0, 5'd5);
    tick();
    chk("add_valid", {31'd0, mw_valid}, 32'd1);
    chk("add_result", mw_result, 32'h0000_1234);
    chk("add_rd", {27'd0, mw_rd}, 32'd5);
    chk("add_wr", {31'd0, mw_reg_write}, 32'd1);
    chk("b2b_ready", {31'd0, em_ready}, 32'd1);
    drive(OPCODE_REG_IMM, 3'd0, 32'h0000_0055, 32'd0, 5'd0);
    tick();
    chk("addi_x0_result", mw_result, 32'h0000_0055);
    chk("addi_x0_wr", {31'd0, mw_reg_write}, 32'd0);
    drive(OPCODE_BRANCH, 3'd0, 32'h0000_0001, 32'd0, 5'd5);
    tick();
    chk("branch_valid", {31'd0, mw_valid}, 32'd1);
    chk("branch_wr", {31'd0, mw_reg_write}, 32'd0);
    drive(OPCODE_JAL, 3'd0, 32'h0000_0404, 32'd0, 5'd1);
    tick();
    chk("jal_result", mw_result, 32'h0000_0404);
    chk("jal_wr", {31'd0, mw_reg_write}, 32'd1);
    em_valid = 1'b0;
    tick();
    chk("drain_idle", {31'd0, mw_valid}, 32'd0);

    // SB with one wait cycle before ack
    drive(OPCODE_STORE, F3_SB, 32'h0000_0103, 32'h0000_00AB, 5'd0);
    tick();
    em_valid = 1'b0;
    chk("sb_req", {31'd0, dmem_req}, 32'd1);
    chk("sb_we", {31'd0, dmem_we}, 32'd1);
    chk("sb_addr", dmem_addr, 32'h0000_0100);
    chk("sb_be", {28'd0, dmem_be}, 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    chk("sb_em_ready", {31'd0, em_ready}, 32'd0);
    tick();
    chk("sb_hold_req", {31'd0, dmem_req}, 32'd1);
    chk("sb_hold_addr", dmem_addr, 32'h0000_0100);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("sb_done_req", {31'd0, dmem_req}, 32'd0);
    chk("sb_no_mw", {31'd0, mw_valid}, 32'd0);
    chk("sb_idle_ready", {31'd0, em_ready}, 32'd1);

    // SH and SW lanes
    drive(OPCODE_STORE, F3_SH, 32'h0000_0102, 32'h1234_ABCD, 5'd0);
    tick();
    em_valid = 1'b0;
    chk("sh_be", {28'd0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    drive(OPCODE_STORE, F3_SW, 32'h0000_0104, 32'hCAFE_F00D, 5'd0);
    tick();
    em_valid = 1'b0;
    chk("sw_be", {28'd0, dmem_be}, 32'hF);
    chk("sw_addr", dmem_addr, 32'h0000_0104);
    chk("sw_wdata", dmem_wdata, 32'hCAFE_F00D);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;

    // LB: ack in first request cycle, rvalid two cycles later
    drive(OPCODE_LOAD, F3_LB, 32'h0000_0102, 32'd0, 5'd7);
    tick();
    em_valid = 1'b0;
    chk("lb_req", {31'd0, dmem_req}, 32'd1);
    chk("lb_we", {31'd0, dmem_we}, 32'd0);
    chk("lb_be", {28'd0, dmem_be}, 32'h4);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("lb_resp_req", {31'd0, dmem_req}, 32'd0);
    chk("lb_resp_mw", {31'd0, mw_valid}, 32'd0);
    tick();
    chk("lb_wait_mw", {31'd0, mw_valid}, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0080_0000;
    tick();
    dmem_rvalid = 1'b0;
    chk("lb_valid", {31'd0, mw_valid}, 32'd1);
    chk("lb_result", mw_result, 32'hFFFF_FF80);
    chk("lb_rd", {27'd0, mw_rd}, 32'd7);
    tick();

    // LBU zero-wait: accept t, ack+rvalid at t+1, mw_valid at t+2
    drive(OPCODE_LOAD, F3_LBU, 32'h0000_0102, 32'd0, 5'd8);
    tick();
    em_valid = 1'b0;
    dmem_ack = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h0080_0000;
    tick();
    dmem_ack = 1'b0; dmem_rvalid = 1'b0;
    chk("lbu_valid", {31'd0, mw_valid}, 32'd1);
    chk("lbu_result", mw_result, 32'h0000_0080);
    tick();

    // LH / LHU extension
    drive(OPCODE_LOAD, F3_LH, 32'h0000_0102, 32'd0, 5'd2);
    tick();
    em_valid = 1'b0;
    dmem_ack = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_0000;
    tick();
    chk("lh_result", mw_result, 32'hFFFF_8001);
    drive(OPCODE_LOAD, F3_LHU, 32'h0000_0100, 32'd0, 5'd2);
    dmem_ack = 1'b0; dmem_rvalid = 1'b0;
    tick();
    em_valid = 1'b0;
    dmem_ack = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_F00F;
    tick();
    dmem_ack = 1'b0; dmem_rvalid = 1'b0;
    chk("lhu_result", mw_result, 32'h0000_F00F);
    tick();

    // LW with writeback stalled for three cycles
    drive(OPCODE_LOAD, F3_LW, 32'h0000_0200, 32'd0, 5'd9);
    tick();
    drive(OPCODE_REG_REG, 3'd0, 32'h0000_0077, 32'd0, 5'd3);
    dmem_ack = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    mw_ready = 1'b0;
    tick();
    dmem_ack = 1'b0; dmem_rvalid = 1'b0;
    chk("lw_result", mw_result, 32'hDEAD_BEEF);
    chk("lw_stall_ready", {31'd0, em_ready}, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
    tick();
    dmem_rvalid = 1'b0;
    chk("lw_hold1_result", mw_result, 32'hDEAD_BEEF);
    chk("lw_hold1_rd", {27'd0, mw_rd}, 32'd9);
    tick();
    chk("lw_hold2_result", mw_result, 32'hDEAD_BEEF);
    chk("lw_hold2_valid", {31'd0, mw_valid}, 32'd1);
    chk("lw_hold2_ready", {31'd0, em_ready}, 32'd0);
    mw_ready = 1'b1;
    #1;
    chk("lw_release_ready", {31'd0, em_ready}, 32'd1);
    tick();
    em_valid = 1'b0;
    chk("after_stall_result", mw_result, 32'h0000_0077);
    chk("after_stall_rd", {27'd0, mw_rd}, 32'd3);
    tick();

    // LW at a half-aligned address
    drive(OPCODE_LOAD, F3_LW, 32'h0000_0102, 32'd0, 5'd6);
    tick();
    em_valid = 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    chk("mis_pulse", {31'd0, misalign_exc}, 32'd1);
    chk("mis_no_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_no_mw", {31'd0, mw_valid}, 32'd0);
    chk("mis_ready", {31'd0, em_ready}, 32'd1);
    tick();
    chk("mis_pulse_end", {31'd0, misalign_exc}, 32'd0);
    chk("mis_still_no_mw", {31'd0, mw_valid}, 32'd0);
`else
    chk("mis_off_exc", {31'd0, misalign_exc}, 32'd0);
    chk("mis_off_req", {31'd0, dmem_req}, 32'd1);
    chk("mis_off_addr", dmem_addr, 32'h0000_0100);
    chk("mis_off_be", {28'd0, dmem_be}, 32'hF);
    dmem_ack = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1122_3344;
    tick();
    dmem_ack = 1'b0; dmem_rvalid = 1'b0;
    chk("mis_off_mw", {31'd0, mw_valid}, 32'd1);
    tick();
`endif

    // Reset while a load request is outstanding
    drive(OPCODE_LOAD, F3_LW, 32'h0000_0300, 32'd0, 5'd4);
    tick();
    em_valid = 1'b0;
    chk("rr_req", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_req_low", {31'd0, dmem_req}, 32'd0);
    chk("rr_ready", {31'd0, em_ready}, 32'd1);
    dmem_ack = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    tick();
    dmem_ack = 1'b0; dmem_rvalid = 1'b0;
    chk("rr_late_mw", {31'd0, mw_valid}, 32'd0);
    chk("rr_late_req", {31'd0, dmem_req}, 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
